// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the rv32i core: word-addressed store behind a
// valid/ready request/response pair with a programmable access latency.
module rv32i_dmem_responder #(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned AW          = 5,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        RN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   mem_d [DEPTH];

    logic            in_range;
    logic [AW-1:0]   idx;

    // Any address bit at or above AW makes the access out of range (no aliasing).
    assign in_range = (addr_q[DW-1:AW] == '0);
    assign idx      = addr_q[AW-1:0];

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_d   = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (in_range) begin
                        err_d = 1'b0;
                        if (we_q) begin
                            mem_d[idx] = wdata_q;
                            rdata_d    = '0;
                        end else begin
                            rdata_d = mem_q[idx];
                        end
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            mem_q       <= mem_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: doc/rv32i_dmem_responder.md
# rv32i_dmem_responder

Data-memory responder for the rv32i pipeline core's load/store path. It serves the core's LW/SW requests over a valid/ready request channel and returns results on a valid/ready response channel. It holds a word-addressed data store and adds a configurable access latency, so the core's memory stage can be exercised against a slow memory. It is the memory-side end of the core's data-memory interface.

## Interface
- DEPTH, 32: number of 32-bit words in the store; word-addressed, valid addresses 0..DEPTH-1.
- AW, 5: index width; DEPTH must equal 2**AW.
- WAIT_CYCLES, 2: extra cycles between request acceptance and response; legal range 0..15.

- clk  in  1  clock; all state changes on the rising edge.
- RN  in  1  asynchronous, active-low reset.
- req_valid  in  1  the core presents a request.
- req_ready  out  1  the responder accepts a request this cycle.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  32  word address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  a response is presented.
- rsp_ready  in  1  the core takes the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  the address was out of range.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM has three states:
  - IDLE: req_ready=1.
  - WAIT: counting down.
  - RESP: rsp_valid=1.
- IDLE: on req_valid&&req_ready, latch we, addr and wdata, load cnt=WAIT_CYCLES, and go to WAIT.
- WAIT:
  - If cnt==0, perform the access and go to RESP.
  - Otherwise decrement cnt.
- Access, performed at the WAIT->RESP edge:
  - addr<DEPTH and we=1: mem[addr[AW-1:0]] <= wdata; rsp_rdata=0; rsp_err=0.
  - addr<DEPTH and we=0: rsp_rdata=mem[addr]; rsp_err=0.
  - addr>=DEPTH (any upper bit set): no write; rsp_rdata=0; rsp_err=1.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1. On that edge, go to IDLE and clear rsp_rdata and rsp_err to 0.
- Inputs: req_* are sampled only at the accept edge. Changes to req_* while busy are ignored.
- Requests are not pipelined. Only one request is outstanding at a time.
- Reset (RN low), applied immediately and asynchronously:
  - State=IDLE, cnt=0.
  - All memory words = 0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Reset mid-operation: the request is dropped. A store still in WAIT is not committed, and no response is produced.

## Timing
- Accept at edge N: rsp_valid rises after edge N+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives 1 cycle of latency; WAIT_CYCLES=15 gives 16.
- req_ready is low from after edge N until the edge on which the response handshake completes.
- rsp_ready is high in the first RESP cycle → response consumed at edge M, where M=N+WAIT_CYCLES+2, and req_ready=1 after edge M.
- Next accept is possible at edge M+1. Maximum throughput is 1 request per WAIT_CYCLES+3 cycles.
- Read-after-write: a load accepted after a store's response completes sees the new data.
- No combinational path from req_* or rsp_ready to any output. All outputs are registered or decoded from state.

## Test plan
- Reset then idle: RN low for 2 cycles, then high → req_ready=1, rsp_valid=0, busy=0; a load to addr 7 returns rsp_rdata=0, rsp_err=0.
- Store/load round trip, WAIT_CYCLES=2: SW addr 3, data 0x0000_0005 accepted at edge N → rsp_valid after N+3, rdata=0. Then LW addr 3 → rdata=0x0000_0005, latency 3 cycles.
- Response backpressure: LW addr 3 with rsp_ready held 0 for 5 cycles → rsp_valid and rdata=0x5 stable throughout. req_valid pulses during this time are not accepted, and the response completes on the first rsp_ready=1 edge.
- Out of range: SW addr 32, data 0xDEAD_BEEF → rsp_err=1, rdata=0. A following LW addr 0 returns 0, so no aliasing occurred.
- Zero wait, WAIT_CYCLES=0: back-to-back SW addr 31=0xFFFF_FFFF then LW addr 31 with rsp_ready tied 1 → each rsp_valid appears 1 cycle after accept; the load returns 0xFFFF_FFFF; accepts are 3 cycles apart.
- Reset mid-operation: SW addr 4=0x1234 accepted, RN pulsed low in the WAIT cycle → outputs return to reset values at once, no rsp_valid; a later LW addr 4 returns 0.
